// File: rtl/lsu_master_if.sv
// Bundle of the request/response handshake and the word-wide data-memory port.
// "slave" is the load/store unit's view; "master" is the environment side
// (the MEM stage that issues requests plus the memory that returns RD).
interface lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_pc, dm_addr, dm_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_pc, dm_addr, dm_wdata
  );
endinterface

// File: rtl/lsu_master.sv
// Load/store initiator for a word-only data memory. One request at a time;
// byte/halfword stores are done as read-modify-write of the containing word.
module lsu_master #(
  parameter int DM_BYTES = 12288
) (
  input  logic        clk,
  input  logic        reset,
  lsu_master_if.slave bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;
  logic [31:0] merge_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_err;
  logic        is_load;
  logic        is_sub_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] sub_word;
  logic [31:0] merged;
  logic [3:0]  lane_en;

  // Opcodes below SW are all loads; SB and SH are the only read-modify-write ops.
  assign is_load      = (op_reg < OP_SW);
  assign is_sub_store = (op_reg == OP_SB) || (op_reg == OP_SH);

  // Alignment and range check on the incoming request, evaluated at accept.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_op)
      OP_LW, OP_SW:         req_err = (bus.req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_err = bus.req_addr[0];
      default:              req_err = 1'b0;
    endcase
    if (bus.req_addr >= DM_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // Lane selection and sign/zero extension of the word returned by DM.
  assign byte_sel = bus.dm_rdata[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = addr_reg[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

  // Load result formatting by opcode.
  always_comb begin
    load_ext = bus.dm_rdata;
    case (op_reg)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      default: load_ext = bus.dm_rdata;
    endcase
  end

  // Store data replicated across lanes so each lane only needs an enable.
  assign sub_word = (op_reg == OP_SB) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_en[gi] = (op_reg == OP_SB) ? (addr_reg[1:0] == 2'(gi))
                                           : (addr_reg[1] == 1'(gi / 2));
    assign merged[8*gi +: 8] = lane_en[gi] ? sub_word[8*gi +: 8] : bus.dm_rdata[8*gi +: 8];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake/DM strobes; reset masks every strobe immediately.
  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_wdata  = 32'h0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid) begin
          state_next = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (op_reg == OP_SW) begin
          bus.dm_we    = !reset;
          bus.dm_wdata = wdata_reg;
        end
        state_next = is_sub_store ? WRITE : RESP;
      end
      WRITE: begin
        bus.dm_we    = !reset;
        bus.dm_wdata = merge_reg;
        state_next   = RESP;
      end
      RESP: begin
        bus.rsp_valid = !reset;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches, load result and merge word capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= 3'b000;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      pc_reg    <= 32'h0;
      merge_reg <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.req_valid) begin
        op_reg    <= bus.req_op;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
        pc_reg    <= bus.req_pc;
        err_reg   <= req_err;
        rdata_reg <= 32'h0;
      end
      if (state_reg == ACCESS) begin
        if (is_load) begin
          rdata_reg <= load_ext;
        end
        if (is_sub_store) begin
          merge_reg <= merged;
        end
      end
    end
  end

  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;
  assign bus.dm_pc     = pc_reg;
  assign bus.dm_addr   = {addr_reg[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_master.sv
// Directed and random transactions against lsu_master, with a word memory
// model on the DM port and a byte-level reference model of expected results.
module tb_lsu_master;
  localparam int DM_WORDS = 3072;
  localparam int DM_BYTES = 12288;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_master_if bus();
  lsu_master #(.DM_BYTES(DM_BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem     [DM_WORDS];
  logic [31:0] ref_mem [DM_WORDS];
  logic        pl_en  = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = 32'h0;

  int total = 0;
  int bad   = 0;

  // Data memory: combinational read, write on the clock edge.
  assign bus.dm_rdata = (bus.dm_addr < 32'(DM_BYTES)) ? mem[bus.dm_addr[13:2]] : 32'h0;

  // DM write port, shared with the bench's preload path.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.dm_we && bus.dm_addr < 32'(DM_BYTES)) mem[bus.dm_addr[13:2]] <= bus.dm_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = idx; pl_val = v;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Reference: byte-addressed view of the memory word.
  function automatic void ref_txn(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic err,
                                  output logic [31:0] rdata, output int lat, output int nwr);
    int size, off;
    logic [31:0] w, sh;
    size  = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd3 || op == 3'd4 || op == 3'd7) ? 2 : 1;
    err   = ((addr % size) != 0) || (addr >= 32'(DM_BYTES));
    rdata = 32'h0;
    nwr   = 0;
    lat   = 1;
    if (err) return;
    off = int'(addr % 4);
    w   = ref_mem[addr / 4];
    if (op < 3'd5) begin
      lat = 2;
      sh  = w >> (8 * off);
      case (op)
        3'd1:    rdata = {{24{sh[7]}}, sh[7:0]};
        3'd2:    rdata = {24'h0, sh[7:0]};
        3'd3:    rdata = {{16{sh[15]}}, sh[15:0]};
        3'd4:    rdata = {16'h0, sh[15:0]};
        default: rdata = w;
      endcase
    end else begin
      lat = (op == 3'd5) ? 2 : 3;
      nwr = 1;
      for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wdata[8*k +: 8];
      ref_mem[addr / 4] = w;
    end
  endfunction

  // One transaction with req_valid dropped after accept; starts and ends after a falling edge.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, output logic [31:0] got_rdata);
    logic e_err; logic [31:0] e_rd; int e_lat, e_nwr;
    int lat, nwr, wr_at; logic got; string t;
    t = $sformatf("op%0d@%h", op, addr);
    ref_txn(op, addr, wdata, e_err, e_rd, e_lat, e_nwr);
    check({t, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_pc = pc;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; nwr = 0; wr_at = -1; got = 1'b0; got_rdata = 32'hx;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.dm_we) begin
        nwr++; wr_at = lat;
        check({t, " dm_pc"}, bus.dm_pc, pc);
        check({t, " dm_addr"}, bus.dm_addr, addr & 32'hFFFF_FFFC);
        check({t, " dm_wdata"}, bus.dm_wdata, ref_mem[addr / 4]);
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        got_rdata = bus.rsp_rdata;
        check({t, " rsp_err"}, 32'(bus.rsp_err), 32'(e_err));
        check({t, " rsp_rdata"}, bus.rsp_rdata, e_rd);
      end
    end
    check({t, " rsp_seen"}, 32'(got), 32'd1);
    check({t, " latency"}, 32'(lat), 32'(e_lat));
    check({t, " writes"}, 32'(nwr), 32'(e_nwr));
    if (e_nwr == 1) check({t, " write_cycle"}, 32'(wr_at), 32'(e_lat - 1));
    @(negedge clk);
    check({t, " after_rsp valid/ready"}, {30'h0, bus.rsp_valid, bus.req_ready}, 32'd1);
    if (addr < 32'(DM_BYTES)) check({t, " dm_word"}, mem[addr / 4], ref_mem[addr / 4]);
    $display("txn op=%0d addr=%h wdata=%h err=%0d rdata=%h lat=%0d", op, addr, wdata, e_err, got_rdata, lat);
  endtask

  logic [31:0] rd;
  logic [2:0]  bop   [3];
  logic [31:0] baddr [3];
  logic [31:0] bwd   [3];
  logic [31:0] bpc   [3];
  logic [31:0] b_erd [3];
  int          b_lat [3];
  int          acc_c [3];
  int          rsp_c [3];

  initial begin
    logic e_err; int e_nwr; int idx, nresp, inflight, sel;
    logic [2:0] op; logic [31:0] addr;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_pc = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset dm_we", 32'(bus.dm_we), 32'd0);
    check("reset dm_addr", bus.dm_addr, 32'h0);
    check("reset dm_pc", bus.dm_pc, 32'h0);
    check("reset dm_wdata", bus.dm_wdata, 32'h0);
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    for (int i = DM_WORDS - 4; i < DM_WORDS; i++) preload(i, $urandom);
    preload(4, 32'h8BADF00D);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", 32'(bus.req_ready), 32'd1);

    // Plain word load
    run_txn(3'd0, 32'h10, 32'h0, 32'h100, rd);
    check("LW 0x10 const", rd, 32'h8BADF00D);

    // Sub-word read-modify-write stores
    preload(4, 32'h11223344);
    run_txn(3'd6, 32'h13, 32'h000000AB, 32'h104, rd);
    check("SB word const", mem[4], 32'hAB223344);
    run_txn(3'd7, 32'h10, 32'h0000BEEF, 32'h108, rd);
    check("SH word const", mem[4], 32'hAB22BEEF);

    // Load extension on 0xAB223344
    preload(4, 32'hAB223344);
    run_txn(3'd1, 32'h13, 32'h0, 32'h10C, rd); check("LB 0x13 const", rd, 32'hFFFFFFAB);
    run_txn(3'd2, 32'h13, 32'h0, 32'h110, rd); check("LBU 0x13 const", rd, 32'h000000AB);
    run_txn(3'd3, 32'h12, 32'h0, 32'h114, rd); check("LH 0x12 const", rd, 32'hFFFFAB22);
    run_txn(3'd4, 32'h12, 32'h0, 32'h118, rd); check("LHU 0x12 const", rd, 32'h0000AB22);
    run_txn(3'd1, 32'h10, 32'h0, 32'h11C, rd); check("LB 0x10 const", rd, 32'h00000044);

    // Error cases
    run_txn(3'd0, 32'h12, 32'h0, 32'h120, rd);
    run_txn(3'd7, 32'h11, 32'hFFFF, 32'h124, rd);
    check("SH err word", mem[4], 32'hAB223344);
    run_txn(3'd5, 32'h3000, 32'h55AA55AA, 32'h128, rd);

    // Reset asserted during the write cycle of an SH
    preload(8, 32'hCAFEF00D);
    bus.req_op = 3'd7; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234; bus.req_pc = 32'h12C;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst-mid access dm_we", 32'(bus.dm_we), 32'd0);
    @(negedge clk);
    check("rst-mid write dm_we", 32'(bus.dm_we), 32'd1);
    reset = 1'b1;
    #1 check("rst-mid forced dm_we", 32'(bus.dm_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rst-mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("rst-mid req_ready", 32'(bus.req_ready), 32'd1);
    check("rst-mid rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    check("rst-mid dm word", mem[8], 32'hCAFEF00D);
    $display("txn op=7 addr=00000020 dropped by reset");

    // Back-to-back with req_valid held high
    bop[0] = 3'd0; baddr[0] = 32'h14; bwd[0] = 32'h0;    bpc[0] = 32'h200;
    bop[1] = 3'd5; baddr[1] = 32'h18; bwd[1] = $urandom; bpc[1] = 32'h204;
    bop[2] = 3'd6; baddr[2] = 32'h1D; bwd[2] = $urandom; bpc[2] = 32'h208;
    idx = 0; nresp = 0; inflight = -1;
    bus.req_op = bop[0]; bus.req_addr = baddr[0]; bus.req_wdata = bwd[0]; bus.req_pc = bpc[0];
    bus.req_valid = 1'b1;
    for (int c = 0; c < 60 && nresp < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.dm_we && inflight >= 0) begin
        check("b2b dm_pc", bus.dm_pc, bpc[inflight]);
        check("b2b dm_wdata", bus.dm_wdata, ref_mem[baddr[inflight] / 4]);
      end
      if (bus.rsp_valid) begin
        check("b2b rsp order", 32'(inflight), 32'(nresp));
        check("b2b rsp_rdata", bus.rsp_rdata, b_erd[nresp]);
        rsp_c[nresp] = c;
        nresp++;
      end
      if (bus.req_ready && idx < 3) begin
        acc_c[idx] = c;
        inflight = idx;
        ref_txn(bop[idx], baddr[idx], bwd[idx], e_err, b_erd[idx], b_lat[idx], e_nwr);
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) begin
          bus.req_op = bop[idx]; bus.req_addr = baddr[idx];
          bus.req_wdata = bwd[idx]; bus.req_pc = bpc[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b responses", 32'(nresp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b latency %0d", i), 32'(rsp_c[i] - acc_c[i]), 32'(b_lat[i]));
      if (i < 2) check($sformatf("b2b next accept %0d", i), 32'(acc_c[i+1]), 32'(rsp_c[i] + 1));
      $display("txn b2b op=%0d addr=%h accept_cyc=%0d rsp_cyc=%0d", bop[i], baddr[i], acc_c[i], rsp_c[i]);
    end
    @(negedge clk);
    check("b2b word 0x18", mem[6], ref_mem[6]);
    check("b2b word 0x1C", mem[7], ref_mem[7]);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = 32'($urandom_range(0, 127));
      else if (sel < 9) addr = 32'($urandom_range(DM_BYTES - 16, DM_BYTES + 7));
      else              addr = $urandom;
      run_txn(op, addr, $urandom, $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
